// File: rtl/down_counter_4bit_jkff.sv
// Synchronous down counter built from JK flip-flop cells, with parallel load,
// zero detect, cascadable borrow-out and a registered underflow pulse.

module jk_ff_sync (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

module down_counter_4bit_jkff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             bo,
    output logic             uf
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_lower_zero;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             r_uf;

    // w_lower_zero[i] is set when every bit below i is 0, i.e. bit i must toggle on a decrement.
    always_comb begin
        logic w_acc;
        w_lower_zero = '0;
        w_acc        = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_lower_zero[i] = w_acc;
            w_acc           = w_acc & ~w_q[i];
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (load) begin
            w_j = din;
            w_k = ~din;
        end else if (en) begin
            w_j = w_lower_zero;
            w_k = w_lower_zero;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff_sync u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (w_j[g]),
            .k     (w_k[g]),
            .q     (w_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_uf <= 1'b0;
        end else begin
            r_uf <= ~load & en & zero;
        end
    end

    assign q    = w_q;
    assign zero = (w_q == '0);
    assign bo   = en & zero & reset;
    assign uf   = r_uf;

endmodule

// File: tb/tb_down_counter_4bit_jkff.sv
// Self-checking bench for down_counter_4bit_jkff: directed scenarios plus
// randomized stimulus against an arithmetic reference model.

module tb_down_counter_4bit_jkff;

    logic       clk = 1'b0;
    logic       reset, en, load;
    logic [3:0] din;
    logic [3:0] q;
    logic       zero, bo, uf;

    logic       c_reset, c_en, c_load;
    logic [3:0] c_din_lo, c_din_hi;
    logic [3:0] lo_q, hi_q;
    logic       lo_zero, lo_bo, lo_uf, hi_zero, hi_bo, hi_uf;

    int n_pass  = 0;
    int n_total = 0;
    int m_q     = 0;
    bit m_uf    = 1'b0;

    always #5 clk = ~clk;

    down_counter_4bit_jkff #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .q(q), .zero(zero), .bo(bo), .uf(uf)
    );

    down_counter_4bit_jkff #(.WIDTH(4)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .load(c_load), .din(c_din_lo),
        .q(lo_q), .zero(lo_zero), .bo(lo_bo), .uf(lo_uf)
    );

    down_counter_4bit_jkff #(.WIDTH(4)) u_hi (
        .clk(clk), .reset(c_reset), .en(lo_bo), .load(c_load), .din(c_din_hi),
        .q(hi_q), .zero(hi_zero), .bo(hi_bo), .uf(hi_uf)
    );

    // Reference: a plain integer counting down modulo 16.
    task automatic tick();
        if (!reset) begin
            m_q = 0; m_uf = 1'b0;
        end else if (load) begin
            m_q = int'(din); m_uf = 1'b0;
        end else if (en) begin
            m_uf = (m_q == 0);
            m_q  = (m_q + 16 - 1) % 16;
        end else begin
            m_uf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; load = 1'b1; din = 4'h9;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++; if (q !== 4'h0) $display("FAIL reset_q got %h want 0", q); else n_pass++;
            n_total++; if (uf !== 1'b0) $display("FAIL reset_uf got %b want 0", uf); else n_pass++;
            n_total++; if (zero !== 1'b1) $display("FAIL reset_zero got %b want 1", zero); else n_pass++;
            n_total++; if (bo !== 1'b0) $display("FAIL reset_bo got %b want 0", bo); else n_pass++;
        end
        reset = 1'b1; load = 1'b0; en = 1'b1;
        tick();
        n_total++; if (q !== 4'hF) $display("FAIL reset_release_q got %h want f", q); else n_pass++;
        n_total++; if (uf !== 1'b1) $display("FAIL reset_release_uf got %b want 1", uf); else n_pass++;
    endtask

    task automatic test_countdown();
        logic [3:0] exp_seq [7] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
        load = 1'b1; en = 1'b0; din = 4'h5;
        tick();
        load = 1'b0; en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_total++; if (q !== exp_seq[c]) $display("FAIL count_q step %0d got %h want %h", c, q, exp_seq[c]); else n_pass++;
            n_total++; if (zero !== (exp_seq[c] == 4'h0)) $display("FAIL count_zero step %0d got %b", c, zero); else n_pass++;
            n_total++; if (bo !== (exp_seq[c] == 4'h0)) $display("FAIL count_bo step %0d got %b", c, bo); else n_pass++;
            n_total++; if (uf !== (exp_seq[c] == 4'hF)) $display("FAIL count_uf step %0d got %b", c, uf); else n_pass++;
        end
    endtask

    task automatic test_priority();
        load = 1'b1; en = 1'b0; din = 4'h3;
        tick();
        load = 1'b1; en = 1'b1; din = 4'hA;
        tick();
        n_total++; if (q !== 4'hA) $display("FAIL priority_q got %h want a", q); else n_pass++;
        n_total++; if (uf !== 1'b0) $display("FAIL priority_uf got %b want 0", uf); else n_pass++;
    endtask

    task automatic test_hold();
        load = 1'b1; en = 1'b0; din = 4'h7;
        tick();
        load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++; if (q !== 4'h7) $display("FAIL hold_q got %h want 7", q); else n_pass++;
            n_total++; if (uf !== 1'b0 || bo !== 1'b0) $display("FAIL hold_flags got uf=%b bo=%b want 0 0", uf, bo); else n_pass++;
        end
        load = 1'b1; din = 4'h0;
        tick();
        load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++; if (q !== 4'h0 || zero !== 1'b1) $display("FAIL hold_zero got q=%h zero=%b want 0 1", q, zero); else n_pass++;
            n_total++; if (uf !== 1'b0 || bo !== 1'b0) $display("FAIL hold_zero_flags got uf=%b bo=%b want 0 0", uf, bo); else n_pass++;
        end
    endtask

    task automatic test_cascade();
        c_load = 1'b1; c_en = 1'b0;
        @(posedge clk); #1;
        c_load = 1'b0;
        n_total++; if ({hi_q, lo_q} !== 8'h10) $display("FAIL cascade_load got %h want 10", {hi_q, lo_q}); else n_pass++;
        c_en = 1'b1;
        @(posedge clk); #1;
        n_total++; if ({hi_q, lo_q} !== 8'h0F) $display("FAIL cascade_step1 got %h want 0f", {hi_q, lo_q}); else n_pass++;
        n_total++; if (hi_uf !== 1'b0) $display("FAIL cascade_hi_uf1 got %b want 0", hi_uf); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({hi_q, lo_q} !== 8'h0E) $display("FAIL cascade_step2 got %h want 0e", {hi_q, lo_q}); else n_pass++;
        n_total++; if (hi_uf !== 1'b0) $display("FAIL cascade_hi_uf2 got %b want 0", hi_uf); else n_pass++;
        c_en = 1'b0;
    endtask

    task automatic test_reset_midcount();
        load = 1'b1; en = 1'b0; din = 4'hC;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        tick();
        n_total++; if (q !== 4'hA) $display("FAIL midcount_pre got %h want a", q); else n_pass++;
        reset = 1'b0;
        tick();
        n_total++; if (q !== 4'h0 || uf !== 1'b0) $display("FAIL midcount_reset got q=%h uf=%b want 0 0", q, uf); else n_pass++;
        reset = 1'b1; en = 1'b0;
        tick();
        n_total++; if (q !== 4'h0 || uf !== 1'b0) $display("FAIL midcount_after got q=%h uf=%b want 0 0", q, uf); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 19) != 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            din   = 4'($urandom_range(0, 15));
            tick();
            n_total++; if (q !== 4'(m_q)) $display("FAIL rand_q cycle %0d got %h want %h", c, q, 4'(m_q)); else n_pass++;
            n_total++; if (uf !== m_uf) $display("FAIL rand_uf cycle %0d got %b want %b", c, uf, m_uf); else n_pass++;
            n_total++; if (zero !== (m_q == 0)) $display("FAIL rand_zero cycle %0d got %b", c, zero); else n_pass++;
            n_total++; if (bo !== (en && reset && m_q == 0)) $display("FAIL rand_bo cycle %0d got %b", c, bo); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; din = 4'h0;
        c_reset = 1'b1; c_en = 1'b0; c_load = 1'b0; c_din_lo = 4'h0; c_din_hi = 4'h1;
        test_reset();
        test_countdown();
        test_priority();
        test_hold();
        test_cascade();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/down_counter_4bit_jkff.md
# down_counter_4bit_jkff

Synchronous down counter built from JK flip-flop cells. It is the counting-down companion to the team's JK up counter. It supports parallel load, count enable, zero detect, a combinational borrow output for cascading stages, and a registered underflow pulse. Typical uses are countdown timers and stage-cascaded prescalers in the same digital-design test collection.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..8.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- en  input  1  count enable; decrement by 1 per enabled clock.
- load  input  1  parallel load strobe; takes priority over en.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  current count (flip-flop outputs).
- zero  output  1  combinational; 1 when q == 0.
- bo  output  1  combinational borrow-out; en & zero & reset. Drives en of the next more-significant stage.
- uf  output  1  registered underflow pulse; 1 for exactly one cycle after a 0 -> max wrap.

## Operation
- Storage: WIDTH JK flip-flop cells, one per bit, plus one D register for uf.
  - The cell is a local module, jk_ff_sync, with a synchronous active-low reset. Its name is distinct from the existing asynchronous jk_ff.
  - The cell truth table is: 00 hold, 01 clear, 10 set, 11 toggle.
- Priority on each rising clk, highest first: reset low, then load, then en, then hold.
- Reset (reset == 0):
  - All q bits go to 0 and uf goes to 0, regardless of load and en.
- Load (load == 1):
  - Each bit i is driven with J = din[i] and K = ~din[i], so q = din on the next edge.
  - uf goes to 0. The en input is ignored that cycle.
- Count (load == 0, en == 1):
  - Bit 0 is driven with J = K = 1 (toggle).
  - Bit i (i ≥ 1) is driven with J = K = ~q[0] & ... & ~q[i-1]. It toggles when all lower bits are 0.
  - Net effect: q_next = (q - 1) mod 2^WIDTH.
- Hold (load == 0, en == 0): every bit gets J = K = 0.
- Wrap-around:
  - With q == 0 and en == 1, q becomes 2^WIDTH - 1 (4'hF for WIDTH = 4).
  - uf is 1 in the following cycle only.
- uf: uf_next = reset & ~load & en & zero. It is held for one cycle and is never sticky.
- Cascading: stage N+1's en is tied to stage N's bo. The chain forms a 2·WIDTH-bit down counter with no extra logic.
- Arithmetic is unsigned modulo 2^WIDTH. There is no saturation.

## Timing
- All state updates occur on the rising clk edge. There are no latches and no asynchronous paths.
- Reset values: q = 0, uf = 0, zero = 1, bo = 0 while reset is low.
- Latency:
  - load to q: 1 cycle.
  - en to q decrement: 1 cycle.
  - zero and bo follow q combinationally in the same cycle.
  - uf asserts 1 cycle after the wrapping edge's inputs are sampled, i.e. coincident with q == max.
- Simultaneous load and en: load wins, q = din, no decrement, uf = 0.
- Simultaneous reset low with load or en: reset wins.
- Reset mid-count: the count is lost and the counter restarts at 0. The first enabled clock after reset release wraps to max and pulses uf.
- Load of 0 followed by en: the next edge wraps to max and pulses uf.
- en deasserted at q == 0: q holds at 0, zero stays 1, bo = 0, uf = 0.

## Test plan
- Reset: hold reset = 0 for 3 cycles with en = 1 and load = 1, din = 4'h9. Required: q = 0, uf = 0, zero = 1, bo = 0 throughout; after release with en = 1, q = 4'hF and uf = 1 on the next cycle.
- Full countdown: load 4'h5, then en = 1 for 7 cycles. Required: q = 4, 3, 2, 1, 0, F, E; zero = 1 only at q = 0; bo = 1 only in that cycle; uf = 1 only in the cycle q = F.
- Priority: q = 4'h3, load = 1, en = 1, din = 4'hA. Required: q = 4'hA next cycle (not 2); uf = 0.
- Hold: q = 4'h7, en = 0 for 5 cycles. Required: q stays 7, uf = 0, bo = 0.
- Cascade: two WIDTH = 4 instances, upper en = lower bo. Load both with 0x10 (lower = 0, upper = 1), then en = 1 for 2 cycles. Required: combined value 0x0F, then 0x0E; upper uf stays 0.
- Reset mid-count: load 4'hC, count 2 cycles (q = A), then reset = 0 for 1 cycle. Required: q = 0 immediately after that edge, with no residual uf.
